// File: rtl/audio_clk_pkg.sv
// Shared defaults and common NCO increments for the audio bit-clock generator.
package audio_clk_pkg;
    localparam int ACC_W_DEF      = 32;
    localparam int FRAME_BITS_DEF = 64;
    // increments for a 64-bit frame clocked from 50 MHz
    localparam int unsigned INC_48K_50M  = 32'd263882791;
    localparam int unsigned INC_44K1_50M = 32'd242442514;
endpackage

// File: rtl/audio_phase_acc.sv
// Fractional phase accumulator: exposes the carry of the current addition and
// a registered copy of it one cycle later.
module audio_phase_acc #(
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             carry_nxt_o,
    output logic             carry_o
);
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] r_acc;
    logic             r_carry;

    assign w_sum       = {1'b0, r_acc} + {1'b0, inc_i};
    assign carry_nxt_o = en_i & ~clr_i & w_sum[ACC_W];
    assign carry_o     = r_carry;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (en_i) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_carry <= w_sum[ACC_W];
        end else begin
            r_carry <= 1'b0;
        end
    end
endmodule

// File: rtl/audio_clk_gen.sv
// Audio bit-clock / frame / LR clock generator driven by an NCO, with a
// start-up hold-off and frame-aligned increment updates.
module audio_clk_gen
    import audio_clk_pkg::*;
#(
    parameter int               ACC_W          = ACC_W_DEF,
    parameter int               FRAME_BITS     = FRAME_BITS_DEF,
    parameter int               STARTUP_CYCLES = 1024,
    parameter logic [ACC_W-1:0] DEFAULT_INC    = ACC_W'(INC_48K_50M),
    localparam int              IDX_W          = $clog2(FRAME_BITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             inc_wr_i,
    output logic             inc_busy_o,
    output logic             ready_o,
    output logic             bit_tick_o,
    output logic             frame_tick_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic             lrclk_o
);
    localparam int CNT_W = $clog2(STARTUP_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic [ACC_W-1:0] r_inc_act;
    logic [ACC_W-1:0] r_inc_pend;
    logic             r_busy;
    logic [IDX_W-1:0] r_idx;
    logic             r_frame;
    logic             w_run;
    logic             w_carry_nxt;
    logic             w_carry;
    logic             w_bnd;

    assign w_run = r_ready & enable_i;
    // the addition that wraps the bit index is the frame boundary
    assign w_bnd = w_carry_nxt & (r_idx == IDX_W'(FRAME_BITS - 1));

    audio_phase_acc #(.ACC_W(ACC_W)) u_acc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (~w_run),
        .en_i        (w_run),
        .inc_i       (r_inc_act),
        .carry_nxt_o (w_carry_nxt),
        .carry_o     (w_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (!r_ready) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_ready <= (r_cnt == CNT_W'(STARTUP_CYCLES - 1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !w_run) begin
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_bnd;
            if (w_carry_nxt)
                r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inc_act  <= DEFAULT_INC;
            r_inc_pend <= '0;
            r_busy     <= 1'b0;
        end else if (r_busy) begin
            if (!w_run || w_bnd) begin
                r_inc_act <= r_inc_pend;
                r_busy    <= 1'b0;
            end
        end else if (inc_wr_i) begin
            r_inc_pend <= inc_i;
            r_busy     <= 1'b1;
        end
    end

    assign inc_busy_o   = r_busy;
    assign ready_o      = r_ready;
    assign bit_tick_o   = w_carry;
    assign frame_tick_o = r_frame;
    assign bit_idx_o    = r_idx;
    assign lrclk_o      = r_idx[IDX_W-1];
endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen with an 8-bit accumulator and 4-bit frames.
module tb_audio_clk_gen;
    localparam int AW = 8;
    localparam int FB = 4;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          rst, en, wr;
    logic [AW-1:0] inc;
    logic          busy, ready, tick, frame, lrclk;
    logic [1:0]    idx;

    int checks = 0;
    int errors = 0;
    int since  = 0;

    audio_clk_gen #(
        .ACC_W(AW), .FRAME_BITS(FB), .STARTUP_CYCLES(SC), .DEFAULT_INC(8'd64)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .inc_i(inc), .inc_wr_i(wr),
        .inc_busy_o(busy), .ready_o(ready), .bit_tick_o(tick),
        .frame_tick_o(frame), .bit_idx_o(idx), .lrclk_o(lrclk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        since++;
    endtask

    task automatic wait_tick(input string tag, input int gap, input int eidx);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 20);
        chk({tag, "_seen"}, 32'(tick), 1);
        chk({tag, "_gap"}, since, gap);
        chk({tag, "_idx"}, 32'(idx), eidx);
        chk({tag, "_frame"}, 32'(frame), (eidx == 0) ? 1 : 0);
        chk({tag, "_lr"}, 32'(lrclk), (eidx >= 2) ? 1 : 0);
        since = 0;
    endtask

    task automatic startup();
        for (int k = 1; k <= SC; k++) begin
            step();
            chk($sformatf("ready_c%0d", k), 32'(ready), (k == SC) ? 1 : 0);
            chk($sformatf("tick_c%0d", k), 32'(tick), 0);
        end
        since = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_frame"}, 32'(frame), 0);
        chk({tag, "_idx"}, 32'(idx), 0);
        chk({tag, "_lr"}, 32'(lrclk), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr = 1'b0; inc = '0;
        step(); step();
        chk_idle("rst");
        rst = 1'b0;
        startup();

        // default inc 64: one tick every 4 run cycles
        wait_tick("t1", 4, 1);
        wait_tick("t2", 4, 2);
        wait_tick("t3", 4, 3);
        wait_tick("t0", 4, 0);
        wait_tick("t1b", 4, 1);

        // rate change mid-frame, applied at the frame wrap
        wr = 1'b1; inc = 8'd128;
        step();
        wr = 1'b0;
        chk("rc_busy", 32'(busy), 1);
        wait_tick("rc2", 4, 2);
        wait_tick("rc3", 4, 3);
        chk("rc_busy3", 32'(busy), 1);
        wait_tick("rc0", 4, 0);
        chk("rc_busy0", 32'(busy), 0);
        wait_tick("rc1", 2, 1);

        // reset with a pending increment discards it
        wr = 1'b1; inc = 8'd32;
        step();
        wr = 1'b0;
        chk("rr_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        chk_idle("rr");
        rst = 1'b0;
        startup();
        wait_tick("rr1", 4, 1);
        wait_tick("rr2", 4, 2);
        wait_tick("rr3", 4, 3);
        wait_tick("rr0", 4, 0);
        wait_tick("rr1b", 4, 1);
        wait_tick("rr2b", 4, 2);

        // enable drop at idx 2 for 3 cycles
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ed_tick%0d", k), 32'(tick), 0);
            chk($sformatf("ed_idx%0d", k), 32'(idx), 0);
        end
        en = 1'b1;
        since = 0;
        wait_tick("ed1", 4, 1);

        // second write while busy is ignored
        wr = 1'b1; inc = 8'd128;
        step();
        inc = 8'd32;
        step();
        wr = 1'b0;
        chk("dw_busy", 32'(busy), 1);
        wait_tick("dw2", 4, 2);
        wait_tick("dw3", 4, 3);
        wait_tick("dw0", 4, 0);
        chk("dw_busy0", 32'(busy), 0);
        wait_tick("dw1", 2, 1);
        wait_tick("dw2b", 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
